// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit and a synchronous memory.
//   imem_addr  : word-aligned byte address of the read
//   imem_rd    : read strobe; data follows on imem_rdata one cycle later
//   imem_rdata : read data returned by the memory
// master = fetch unit side, slave = memory side.
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_rdata;

    modport master (
        output imem_addr,
        output imem_rd,
        input  imem_rdata
    );

    modport slave (
        input  imem_addr,
        input  imem_rd,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage feeding the decode pipeline register.
// Owns the PC, issues one word read per cycle to a synchronous instruction
// memory, buffers returned words in a small FIFO and presents one
// instruction per cycle tagged with its branch epoch. Every redirect from
// execute flips the epoch so decode can squash wrong-path instructions.
//
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   sel_stall       : decode holds its register; head is not popped
//   redirect_valid  : taken branch / PC write from execute
//   redirect_pc     : redirect target (bits [1:0] forced to 0)
//   imem            : instruction memory bus (master side)
//   instr_out       : instruction to decode (NOP when FIFO is empty)
//   branch_out      : epoch tag of instr_out
//   branch_ref      : current epoch
//   pc_out          : byte address of instr_out (0 when FIFO is empty)
//
// DEPTH must lie in 2..4.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    fetch_unit_if.master        imem,
    output logic [31:0]         instr_out,
    output logic                branch_out,
    output logic                branch_ref,
    output logic [31:0]         pc_out
);

    localparam logic [31:0] NOP     = 32'hE320_F000;
    localparam logic [3:0]  DEPTH_W = 4'(DEPTH);
    localparam logic [1:0]  LAST    = 2'(DEPTH - 1);

    // Request stage: PC and epoch
    logic [31:0] pc_p0;
    logic        epoch;

    // Response stage: read in flight, tagged with the PC and epoch it was issued under
    logic        vld_p1;
    logic [31:0] pc_p1;
    logic        epoch_p1;

    // Fetch FIFO; storage is sized for the largest legal DEPTH and the
    // pointers wrap at DEPTH-1.
    logic [31:0] fifo_instr [4];
    logic [31:0] fifo_pc    [4];
    logic        fifo_epoch [4];
    logic [1:0]  rd_ptr;
    logic [1:0]  wr_ptr;
    logic [2:0]  count;

    logic        pop;
    logic        push;
    logic        issue;
    logic [3:0]  occupancy;
    logic [2:0]  count_next;
    logic        has_head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == LAST) ? 2'd0 : p + 2'd1;
    endfunction

    assign has_head = (count != 3'd0);
    assign pop      = !sel_stall && has_head && !redirect_valid;
    // A response from an older epoch is wrong-path and is dropped.
    assign push     = vld_p1 && (epoch_p1 == epoch);

    // The in-flight read reserves a slot even before it lands, so the FIFO
    // can never be asked to accept more than DEPTH entries.
    assign occupancy  = {1'b0, count} + {3'b000, vld_p1} - {3'b000, pop};
    assign issue      = rst_n && !redirect_valid && (occupancy < DEPTH_W);
    assign count_next = count + {2'b00, push} - {2'b00, pop};

    assign imem.imem_addr = pc_p0;
    assign imem.imem_rd   = issue;

    assign instr_out  = has_head ? fifo_instr[rd_ptr] : NOP;
    assign branch_out = has_head ? fifo_epoch[rd_ptr] : epoch;
    assign pc_out     = has_head ? fifo_pc[rd_ptr]    : 32'h0000_0000;
    assign branch_ref = epoch;

    // Control state: PC, epoch, in-flight flag and FIFO bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_p0  <= RESET_PC;
            epoch  <= 1'b0;
            vld_p1 <= 1'b0;
            count  <= 3'd0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
        end else if (redirect_valid) begin
            // Flush everything; the in-flight read is dropped here and any
            // later response from the old path fails the epoch match.
            pc_p0  <= {redirect_pc[31:2], 2'b00};
            epoch  <= ~epoch;
            vld_p1 <= 1'b0;
            count  <= 3'd0;
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
        end else begin
            vld_p1 <= issue;
            if (issue) begin
                pc_p0 <= pc_p0 + 32'd4;
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            count <= count_next;
            assert (count_next <= DEPTH_W);
        end
    end

    // Data path: request tags and FIFO payload
    always_ff @(posedge clk) begin
        if (issue) begin
            pc_p1    <= pc_p0;
            epoch_p1 <= epoch;
        end
        if (push) begin
            fifo_instr[wr_ptr] <= imem.imem_rdata;
            fifo_pc[wr_ptr]    <= pc_p1;
            fifo_epoch[wr_ptr] <= epoch_p1;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: startup, stall, redirects, PC wrap and
// mid-operation reset. Memory returns word[n] = n for byte address 4n.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'hE320_F000;

    logic        clk;
    logic        rst_n;
    logic        sel_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic [31:0] instr_a, pc_a, instr_b, pc_b;
    logic        br_a, ref_a, br_b, ref_b;

    int n_cmp;
    int n_err;

    fetch_unit_if bus_a ();
    fetch_unit_if bus_b ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut_a (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel_stall      (sel_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (bus_a.master),
        .instr_out      (instr_a),
        .branch_out     (br_a),
        .branch_ref     (ref_a),
        .pc_out         (pc_a)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_b (
        .clk            (clk),
        .rst_n          (rst_n),
        .sel_stall      (1'b0),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0000_0000),
        .imem           (bus_b.master),
        .instr_out      (instr_b),
        .branch_out     (br_b),
        .branch_ref     (ref_b),
        .pc_out         (pc_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memories: word index of the address, one cycle later
    always @(posedge clk) begin
        if (bus_a.imem_rd) bus_a.imem_rdata <= {2'b00, bus_a.imem_addr[31:2]};
        if (bus_b.imem_rd) bus_b.imem_rdata <= {2'b00, bus_b.imem_addr[31:2]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the head of dut_a
    task automatic chk_head(input string tag, input logic [31:0] instr,
                            input logic [31:0] pc, input logic br);
        chk({tag, ".instr"}, instr_a, instr);
        chk({tag, ".pc"}, pc_a, pc);
        chk({tag, ".br"}, {31'd0, br_a}, {31'd0, br});
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        bus_a.imem_rdata = 32'd0;
        bus_b.imem_rdata = 32'd0;
        rst_n          = 1'b0;
        sel_stall      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;

        step();
        step();
        // Reset state
        chk_head("rst", NOP, 32'd0, 1'b0);
        chk("rst.ref", {31'd0, ref_a}, 32'd0);
        chk("rst.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        chk("rst.addr", bus_a.imem_addr, 32'd0);

        // Cycle 0 after release
        rst_n = 1'b1;
        #1;
        chk("c0.rd", {31'd0, bus_a.imem_rd}, 32'd1);
        chk("c0.addr", bus_a.imem_addr, 32'd0);
        chk("c0.instr", instr_a, NOP);
        chk("wrap.c0", bus_b.imem_addr, 32'hFFFF_FFF8);
        step();  // cycle 1
        chk("c1.instr", instr_a, NOP);
        chk("c1.addr", bus_a.imem_addr, 32'd4);
        chk("wrap.c1", bus_b.imem_addr, 32'hFFFF_FFFC);
        step();  // cycle 2
        chk_head("c2", 32'd0, 32'd0, 1'b0);
        chk("wrap.c2", bus_b.imem_addr, 32'h0000_0000);
        chk("wrap.head", instr_b, 32'h3FFF_FFFE);
        chk("wrap.pc", pc_b, 32'hFFFF_FFF8);
        step();
        chk_head("c3", 32'd1, 32'd4, 1'b0);
        step();
        chk_head("c4", 32'd2, 32'd8, 1'b0);
        step();  // cycle 5
        chk_head("c5", 32'd3, 32'd12, 1'b0);

        // Stall for cycles 5..9
        sel_stall = 1'b1;
        #1;
        chk("stall.c5.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        for (int i = 6; i <= 9; i++) begin
            step();
            chk("stall.instr", instr_a, 32'd3);
            chk("stall.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        end
        step();  // cycle 10: release
        sel_stall = 1'b0;
        #1;
        chk("rel.rd", {31'd0, bus_a.imem_rd}, 32'd1);
        chk("rel.addr", bus_a.imem_addr, 32'd20);
        chk_head("c10", 32'd3, 32'd12, 1'b0);
        step();
        chk_head("c11", 32'd4, 32'd16, 1'b0);
        step();
        chk_head("c12", 32'd5, 32'd20, 1'b0);
        step();  // cycle 13
        chk_head("c13", 32'd6, 32'd24, 1'b0);

        // Redirect to 0x103 during cycle 13
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        #1;
        chk("redir.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        chk("redir.ref_before", {31'd0, ref_a}, 32'd0);
        step();  // cycle 14
        redirect_valid = 1'b0;
        #1;
        chk("redir.ref_after", {31'd0, ref_a}, 32'd1);
        chk("redir.addr", bus_a.imem_addr, 32'h0000_0100);
        chk("redir.rd1", {31'd0, bus_a.imem_rd}, 32'd1);
        chk_head("c14", NOP, 32'd0, 1'b1);
        step();
        chk_head("c15", NOP, 32'd0, 1'b1);
        step();
        chk_head("c16", 32'h40, 32'h100, 1'b1);
        step();  // cycle 17
        chk_head("c17", 32'h41, 32'h104, 1'b1);

        // Stall, then redirect under stall, then back-to-back redirects
        sel_stall = 1'b1;
        step();  // cycle 18
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        chk_head("c18", 32'h41, 32'h104, 1'b1);
        chk("c18.ref", {31'd0, ref_a}, 32'd1);
        step();  // cycle 19
        redirect_pc = 32'h0000_0300;
        #1;
        chk("c19.ref", {31'd0, ref_a}, 32'd0);
        chk("c19.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        chk_head("c19", NOP, 32'd0, 1'b0);
        step();  // cycle 20
        redirect_valid = 1'b0;
        sel_stall      = 1'b0;
        #1;
        chk("c20.ref", {31'd0, ref_a}, 32'd1);
        chk("c20.addr", bus_a.imem_addr, 32'h0000_0300);
        chk("c20.rd", {31'd0, bus_a.imem_rd}, 32'd1);
        step();
        chk_head("c21", NOP, 32'd0, 1'b1);
        step();
        chk_head("c22", 32'hC0, 32'h300, 1'b1);
        step();
        chk_head("c23", 32'hC1, 32'h304, 1'b1);
        step();  // cycle 24: head C2, C3 in flight
        chk_head("c24", 32'hC2, 32'h308, 1'b1);

        // Reset mid-stream
        rst_n = 1'b0;
        step();  // cycle 25
        chk_head("mrst", NOP, 32'd0, 1'b0);
        chk("mrst.ref", {31'd0, ref_a}, 32'd0);
        chk("mrst.rd", {31'd0, bus_a.imem_rd}, 32'd0);
        chk("mrst.addr", bus_a.imem_addr, 32'd0);
        rst_n = 1'b1;
        step();  // cycle 26: dropped C3 must not appear
        chk_head("c26", NOP, 32'd0, 1'b0);
        step();
        chk_head("c27", 32'd0, 32'd0, 1'b0);
        step();
        chk_head("c28", 32'd1, 32'd4, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
